mmio_hub: RTL and testbench



---
 rtl/mmio_hub_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 57 +++++
 rtl/mmio_hub.sv | 128 ++++++++++++
 tb/tb_mmio_hub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_hub_pkg.sv
// mmio_hub_pkg: shared constants for the memory-mapped I/O hub.
//   REGION_BIT      address bit that selects RAM (0) or the IO window (1)
//   OFF_*           IO window register offsets (address[3:0])
//   hub_id()        builds the HUB_ID identification byte
package mmio_hub_pkg;

  localparam int REGION_BIT = 13;

  localparam logic [3:0] OFF_BTN_LEVEL = 4'h0;
  localparam logic [3:0] OFF_LED       = 4'h1;
  localparam logic [3:0] OFF_BTN_EDGE  = 4'h2;
  localparam logic [3:0] OFF_LED_SET   = 4'h3;
  localparam logic [3:0] OFF_LED_CLR   = 4'h4;
  localparam logic [3:0] OFF_HUB_ID    = 4'h5;

  typedef enum logic {
    REGION_RAM = 1'b0,
    REGION_IO  = 1'b1
  } region_e;

  // {button count - 1, LED count - 1}, one nibble each.
  function automatic logic [7:0] hub_id(input int num_btn, input int num_led);
    return {4'(num_btn - 1), 4'(num_led - 1)};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a stability counter.
//   clk, rst_n  clock and asynchronous active-low reset
//   raw         asynchronous button pin, active-high
//   level       debounced level
//   rise        one-cycle pulse, high during the cycle whose closing edge
//               flips level from 0 to 1 (so a register sampling it sets on
//               the same edge as level)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised sample disagrees with the
  // accepted level; any agreement restarts it, so short glitches never flip.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = sync2_q & ~level_q & (cnt_q == LAST);

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: data RAM plus an IO register window (debounced buttons, LEDs).
//   clk, rst_n  clock and asynchronous active-low reset
//   address     CPU word address; bit 13 selects RAM (0) or IO (1)
//   load        write strobe, sampled on the rising clock edge
//   in          write data
//   out         read data, one cycle after the address (old data on
//               read-during-write)
//   btn         raw button pins, active-high
//   led         LED drive, active-high
// IO map (address[3:0]): 0 BTN_LEVEL ro, 1 LED rw, 2 BTN_EDGE w1c,
// 3 LED_SET wo, 4 LED_CLR wo, 5 HUB_ID ro, others read 0.
module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int NUM_LED         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RAM_AW          = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        address,
  input  logic               load,
  input  logic [15:0]        in,
  output logic [15:0]        out,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_LED-1:0] led
);

  // ---------------- decode ----------------
  region_e           region;
  logic [3:0]        io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_ram, wr_io;

  assign region  = region_e'(address[REGION_BIT]);
  assign io_off  = address[3:0];
  assign ram_idx = address[RAM_AW-1:0];
  assign wr_ram  = load & (region == REGION_RAM);
  assign wr_io   = load & (region == REGION_IO);

  // Address bits outside the decode and data bits above the LED width.
  logic unused_bits;
  assign unused_bits = ^{address, in};

  // ---------------- buttons ----------------
  logic [NUM_BTN-1:0] level_vec, rise_vec;

  for (genvar g = 0; g < NUM_BTN; g++) begin : gen_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn[g]),
      .level(level_vec[g]),
      .rise (rise_vec[g])
    );
  end

  // ---------------- register file ----------------
  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_BTN-1:0] edge_q, edge_d, edge_clr;

  always_comb begin
    led_d = led_q;
    if (wr_io) begin
      case (io_off)
        OFF_LED:     led_d = in[NUM_LED-1:0];
        OFF_LED_SET: led_d = led_q | in[NUM_LED-1:0];
        OFF_LED_CLR: led_d = led_q & ~in[NUM_LED-1:0];
        default:     led_d = led_q;
      endcase
    end
  end

  // Clear is applied first and the new rise OR-ed in after, so a rise that
  // lands on the same edge as its W1C survives.
  assign edge_clr = (wr_io && io_off == OFF_BTN_EDGE) ? in[NUM_BTN-1:0] : '0;
  assign edge_d   = (edge_q & ~edge_clr) | rise_vec;

  // ---------------- read path ----------------
  logic [15:0] io_rd;

  always_comb begin
    io_rd = '0;
    case (io_off)
      OFF_BTN_LEVEL: io_rd[NUM_BTN-1:0] = level_vec;
      OFF_LED:       io_rd[NUM_LED-1:0] = led_q;
      OFF_BTN_EDGE:  io_rd[NUM_BTN-1:0] = edge_q;
      OFF_HUB_ID:    io_rd[7:0]         = hub_id(NUM_BTN, NUM_LED);
      default:       io_rd              = '0;
    endcase
  end

  // The RAM and its read register carry no reset so the array can map onto
  // block memory. The output mux select resets to the IO side with a zeroed
  // IO read register, which makes out read 0 during and after reset.
  logic [15:0] mem_q [2**RAM_AW];
  logic [15:0] ram_rd_q;
  logic [15:0] io_rd_q;
  logic        sel_io_q;

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      mem_q[ram_idx] <= in;
    end
    ram_rd_q <= mem_q[ram_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= '0;
      edge_q   <= '0;
      io_rd_q  <= '0;
      sel_io_q <= 1'b1;
    end else begin
      led_q    <= led_d;
      edge_q   <= edge_d;
      io_rd_q  <= io_rd;
      sel_io_q <= (region == REGION_IO);
    end
  end

  assign out = sel_io_q ? io_rd_q : ram_rd_q;
  assign led = led_q;

endmodule

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: directed self-checking bench for mmio_hub with a short
// debounce window (4 cycles). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_mmio_hub;

  localparam int NB = 4;
  localparam int NL = 4;
  localparam int DB = 4;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   address = '0;
  logic          load = 1'b0;
  logic [15:0]   din = '0;
  logic [15:0]   dout;
  logic [NB-1:0] btn = '0;
  logic [NL-1:0] led;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mmio_hub #(
    .NUM_BTN        (NB),
    .NUM_LED        (NL),
    .DEBOUNCE_CYCLES(DB),
    .RAM_AW         (AW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .address(address),
    .load   (load),
    .in     (din),
    .out    (dout),
    .btn    (btn),
    .led    (led)
  );

  // ---------------- drivers (entered and left on a falling edge) ----------------
  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    address = a;
    din     = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic read_word(input logic [15:0] a, output logic [15:0] d);
    address = a;
    load    = 1'b0;
    @(negedge clk);
    d = dout;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] r;
    rst_n = 1'b0;
    btn   = '1;
    repeat (3) @(negedge clk);
    n_total++; if (led !== 4'h0) $display("FAIL reset_led: got %h expected %h", led, 4'h0); else n_pass++;
    n_total++; if (dout !== 16'h0000) $display("FAIL reset_out: got %h expected %h", dout, 16'h0000); else n_pass++;
    btn   = '0;
    rst_n = 1'b1;
    read_word(16'h2005, r);
    n_total++; if (r !== 16'h0033) $display("FAIL hub_id: got %h expected %h", r, 16'h0033); else n_pass++;
    read_word(16'hEFF5, r);
    n_total++; if (r !== 16'h0033) $display("FAIL hub_id_alias: got %h expected %h", r, 16'h0033); else n_pass++;
  endtask

  task automatic test_ram_io();
    logic [15:0] r;
    write_word(16'h0010, 16'hBEEF);
    write_word(16'h2001, 16'h0005);
    read_word(16'h0010, r);
    n_total++; if (r !== 16'hBEEF) $display("FAIL ram_read: got %h expected %h", r, 16'hBEEF); else n_pass++;
    read_word(16'hC010, r);
    n_total++; if (r !== 16'hBEEF) $display("FAIL ram_alias: got %h expected %h", r, 16'hBEEF); else n_pass++;
    read_word(16'h2001, r);
    n_total++; if (r !== 16'h0005) $display("FAIL led_reg_read: got %h expected %h", r, 16'h0005); else n_pass++;
    n_total++; if (led !== 4'b0101) $display("FAIL led_pins: got %b expected %b", led, 4'b0101); else n_pass++;
  endtask

  task automatic test_led_atomic();
    logic [15:0] r;
    write_word(16'h2001, 16'h0003);
    write_word(16'h2003, 16'h0004);
    n_total++; if (led !== 4'h7) $display("FAIL led_set: got %h expected %h", led, 4'h7); else n_pass++;
    write_word(16'h2004, 16'h0001);
    n_total++; if (led !== 4'h6) $display("FAIL led_clr: got %h expected %h", led, 4'h6); else n_pass++;
    read_word(16'h2003, r);
    n_total++; if (r !== 16'h0000) $display("FAIL led_set_reads0: got %h expected %h", r, 16'h0000); else n_pass++;
    read_word(16'h2004, r);
    n_total++; if (r !== 16'h0000) $display("FAIL led_clr_reads0: got %h expected %h", r, 16'h0000); else n_pass++;
    read_word(16'h2001, r);
    n_total++; if (r !== 16'h0006) $display("FAIL led_after_ops: got %h expected %h", r, 16'h0006); else n_pass++;
  endtask

  task automatic test_read_during_write();
    logic [15:0] r;
    write_word(16'h0010, 16'h1234);
    n_total++; if (dout !== 16'hBEEF) $display("FAIL ram_rdw_old: got %h expected %h", dout, 16'hBEEF); else n_pass++;
    read_word(16'h0010, r);
    n_total++; if (r !== 16'h1234) $display("FAIL ram_rdw_new: got %h expected %h", r, 16'h1234); else n_pass++;
    write_word(16'h2001, 16'h0009);
    n_total++; if (dout !== 16'h0006) $display("FAIL led_rdw_old: got %h expected %h", dout, 16'h0006); else n_pass++;
    n_total++; if (led !== 4'h9) $display("FAIL led_rdw_pins: got %h expected %h", led, 4'h9); else n_pass++;
  endtask

  task automatic test_ignored_writes();
    logic [15:0] r;
    write_word(16'h2000, 16'hFFFF);
    read_word(16'h2000, r);
    n_total++; if (r !== 16'h0000) $display("FAIL btn_level_ro: got %h expected %h", r, 16'h0000); else n_pass++;
    write_word(16'h2006, 16'hFFFF);
    read_word(16'h2006, r);
    n_total++; if (r !== 16'h0000) $display("FAIL unused_reg: got %h expected %h", r, 16'h0000); else n_pass++;
    write_word(16'h2005, 16'h0000);
    read_word(16'h2005, r);
    n_total++; if (r !== 16'h0033) $display("FAIL hub_id_ro: got %h expected %h", r, 16'h0033); else n_pass++;
    n_total++; if (led !== 4'h9) $display("FAIL led_untouched: got %h expected %h", led, 4'h9); else n_pass++;
  endtask

  task automatic test_glitch();
    logic [15:0] r;
    btn[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn[0] = 1'b0;
    repeat (6) @(negedge clk);
    read_word(16'h2000, r);
    n_total++; if (r !== 16'h0000) $display("FAIL glitch_level: got %h expected %h", r, 16'h0000); else n_pass++;
    read_word(16'h2002, r);
    n_total++; if (r !== 16'h0000) $display("FAIL glitch_edge: got %h expected %h", r, 16'h0000); else n_pass++;
  endtask

  // Step btn[0]; level and edge change on the 6th rising edge after the step.
  // out shows the value from before the edge it is sampled at.
  task automatic test_debounce();
    address = 16'h2000;
    load    = 1'b0;
    btn[0]  = 1'b1;
    repeat (5) @(negedge clk);
    n_total++; if (dout !== 16'h0000) $display("FAIL level_early: got %h expected %h", dout, 16'h0000); else n_pass++;
    address = 16'h2002;
    @(negedge clk);
    n_total++; if (dout !== 16'h0000) $display("FAIL edge_early: got %h expected %h", dout, 16'h0000); else n_pass++;
    address = 16'h2000;
    @(negedge clk);
    n_total++; if (dout !== 16'h0001) $display("FAIL level_on_time: got %h expected %h", dout, 16'h0001); else n_pass++;
    address = 16'h2002;
    @(negedge clk);
    n_total++; if (dout !== 16'h0001) $display("FAIL edge_on_time: got %h expected %h", dout, 16'h0001); else n_pass++;
  endtask

  task automatic test_w1c();
    logic [15:0] r;
    write_word(16'h2002, 16'h0001);
    read_word(16'h2002, r);
    n_total++; if (r !== 16'h0000) $display("FAIL w1c_clear: got %h expected %h", r, 16'h0000); else n_pass++;
    btn[0] = 1'b0;
    repeat (10) @(negedge clk);
    read_word(16'h2000, r);
    n_total++; if (r !== 16'h0000) $display("FAIL level_fall: got %h expected %h", r, 16'h0000); else n_pass++;
    read_word(16'h2002, r);
    n_total++; if (r !== 16'h0000) $display("FAIL fall_no_edge: got %h expected %h", r, 16'h0000); else n_pass++;
    // New rise lands on the same edge as the W1C of that bit.
    btn[0] = 1'b1;
    repeat (5) @(negedge clk);
    write_word(16'h2002, 16'h0001);
    n_total++; if (dout !== 16'h0000) $display("FAIL collide_old: got %h expected %h", dout, 16'h0000); else n_pass++;
    read_word(16'h2002, r);
    n_total++; if (r !== 16'h0001) $display("FAIL collide_set_wins: got %h expected %h", r, 16'h0001); else n_pass++;
    read_word(16'h2000, r);
    n_total++; if (r !== 16'h0001) $display("FAIL collide_level: got %h expected %h", r, 16'h0001); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [15:0] r;
    write_word(16'h2001, 16'h000F);
    write_word(16'h0020, 16'hA5A5);
    n_total++; if (led !== 4'hF) $display("FAIL led_all_on: got %h expected %h", led, 4'hF); else n_pass++;
    btn = 4'b0010;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (led !== 4'h0) $display("FAIL midrst_led: got %h expected %h", led, 4'h0); else n_pass++;
    n_total++; if (dout !== 16'h0000) $display("FAIL midrst_out: got %h expected %h", dout, 16'h0000); else n_pass++;
    @(negedge clk);
    btn   = '0;
    rst_n = 1'b1;
    read_word(16'h2000, r);
    n_total++; if (r !== 16'h0000) $display("FAIL midrst_level: got %h expected %h", r, 16'h0000); else n_pass++;
    read_word(16'h2002, r);
    n_total++; if (r !== 16'h0000) $display("FAIL midrst_edge: got %h expected %h", r, 16'h0000); else n_pass++;
    read_word(16'h2001, r);
    n_total++; if (r !== 16'h0000) $display("FAIL midrst_led_reg: got %h expected %h", r, 16'h0000); else n_pass++;
    read_word(16'h0020, r);
    n_total++; if (r !== 16'hA5A5) $display("FAIL midrst_ram_kept: got %h expected %h", r, 16'hA5A5); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_ram_io();
    test_led_atomic();
    test_read_during_write();
    test_ignored_writes();
    test_glitch();
    test_debounce();
    test_w1c();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    n_total++;
    $display("FAIL watchdog: run did not complete, got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
